// File: rtl/store_write_buffer_if.sv
// Bundle of ports between the store queue, the load forwarding path, the
// D-cache write port and the post-retirement store write buffer.
interface store_write_buffer_if #(
  parameter int N_WAY  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int FREE_W = $clog2(N_WAY) + 1;

  logic [N_WAY-1:0]        st_valid;
  logic [N_WAY*ADDR_W-1:0] st_addr;
  logic [N_WAY*DATA_W-1:0] st_data;
  logic [FREE_W-1:0]       wb_free;
  logic                    wb_empty;
  logic                    overflow_err;
  logic                    mem_req;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_data;
  logic                    mem_ack;
  logic                    ld_valid;
  logic [ADDR_W-1:0]       ld_addr;
  logic                    ld_hit;
  logic [DATA_W-1:0]       ld_data;

  modport master (
    output st_valid, st_addr, st_data, mem_ack, ld_valid, ld_addr,
    input  wb_free, wb_empty, overflow_err, mem_req, mem_addr, mem_data,
           ld_hit, ld_data
  );

  modport slave (
    input  st_valid, st_addr, st_data, mem_ack, ld_valid, ld_addr,
    output wb_free, wb_empty, overflow_err, mem_req, mem_addr, mem_data,
           ld_hit, ld_data
  );
endinterface

// File: rtl/store_write_buffer.sv
// Circular store write buffer: multi-lane in-order enqueue, single-entry
// drain over mem_req/mem_ack, and youngest-match load forwarding.
//
// state | meaning
// IDLE  | no request outstanding; leaves when the buffer holds an entry
// REQ   | head entry presented on mem_addr/mem_data until mem_ack
module store_write_buffer #(
  parameter int N_WAY    = 2,
  parameter int WB_DEPTH = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input logic                 clock,
  input logic                 reset,
  store_write_buffer_if.slave bus
);
  localparam int PTR_W  = $clog2(WB_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FREE_W = $clog2(N_WAY) + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state_q, state_d;
  logic [WB_DEPTH-1:0] valid_q;
  logic [ADDR_W-1:0]   addr_q [WB_DEPTH];
  logic [DATA_W-1:0]   data_q [WB_DEPTH];
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q, count_d, capacity, enq_n;
  logic                overflow_q, drop, pop, mem_req;
  logic [WB_DEPTH-1:0] wr_en;
  logic [ADDR_W-1:0]   wr_addr [WB_DEPTH];
  logic [DATA_W-1:0]   wr_data [WB_DEPTH];

  // Space is judged on the registered count; a same-cycle pop frees nothing.
  assign capacity = CNT_W'(WB_DEPTH) - count_q;
  assign mem_req  = (state_q == REQ);
  assign pop      = mem_req && bus.mem_ack;
  assign count_d  = count_q + enq_n - CNT_W'(pop);

  // Compact valid lanes into consecutive slots from tail, lane 0 first.
  always_comb begin
    logic [PTR_W-1:0] slot;
    wr_en = '0;
    enq_n = '0;
    drop  = 1'b0;
    slot  = '0;
    for (int w = 0; w < WB_DEPTH; w++) begin
      wr_addr[w] = '0;
      wr_data[w] = '0;
    end
    for (int i = 0; i < N_WAY; i++) begin
      if (bus.st_valid[i]) begin
        if (enq_n < capacity) begin
          slot          = tail_q + enq_n[PTR_W-1:0];
          wr_en[slot]   = 1'b1;
          wr_addr[slot] = bus.st_addr[i*ADDR_W +: ADDR_W];
          wr_data[slot] = bus.st_data[i*DATA_W +: DATA_W];
          enq_n         = enq_n + CNT_W'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = REQ;
      REQ:     if (pop && (count_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Walk oldest to youngest so the last match (closest behind tail) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    bus.ld_hit  = 1'b0;
    bus.ld_data = '0;
    idx         = '0;
    if (bus.ld_valid) begin
      for (int k = WB_DEPTH; k >= 1; k--) begin
        idx = tail_q - PTR_W'(k);
        if (valid_q[idx] && (addr_q[idx] == bus.ld_addr)) begin
          bus.ld_hit  = 1'b1;
          bus.ld_data = data_q[idx];
        end
      end
    end
  end

  assign bus.mem_req      = mem_req;
  assign bus.mem_addr     = mem_req ? addr_q[head_q] : '0;
  assign bus.mem_data     = mem_req ? data_q[head_q] : '0;
  assign bus.wb_empty     = (count_q == '0);
  assign bus.overflow_err = overflow_q;
  assign bus.wb_free      = (capacity > CNT_W'(N_WAY)) ? FREE_W'(N_WAY)
                                                       : FREE_W'(capacity);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= '0;
      for (int w = 0; w < WB_DEPTH; w++) begin
        addr_q[w] <= '0;
        data_q[w] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tail_q  <= tail_q + enq_n[PTR_W-1:0];
      if (drop) overflow_q <= 1'b1;
      // Free slots never include head, so pop and enqueue never collide.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      for (int w = 0; w < WB_DEPTH; w++) begin
        if (wr_en[w]) begin
          valid_q[w] <= 1'b1;
          addr_q[w]  <= wr_addr[w];
          data_q[w]  <= wr_data[w];
        end
      end
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: stimulus queues expected writes,
// a negedge monitor pops and compares every accepted D-cache request.
module tb_store_write_buffer;
  localparam int N_WAY    = 2;
  localparam int WB_DEPTH = 8;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } st_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  store_write_buffer_if #(.N_WAY(N_WAY), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  store_write_buffer #(
    .N_WAY(N_WAY), .WB_DEPTH(WB_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  st_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic lane(input int l, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.st_valid[l] = 1'b1;
    bus.st_addr[l*ADDR_W +: ADDR_W] = a;
    bus.st_data[l*DATA_W +: DATA_W] = d;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    st_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!bus.wb_empty && n < max_cycles) begin
      tick();
      n++;
    end
    chk({name, "_empty"}, bus.wb_empty, 1);
    chk({name, "_sb_left"}, sb.size(), 0);
  endtask

  initial begin
    bit   stalled;
    st_t  held;
    st_t  exp;
    int   issued;
    int   n;

    reset        = 1'b1;
    bus.st_valid = '0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.mem_ack  = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    stalled      = 1'b0;
    held         = '0;

    fork
      forever begin
        @(negedge clock);
        if (bus.mem_req) begin
          if (stalled) begin
            chk("hold_addr", bus.mem_addr, held.addr);
            chk("hold_data", bus.mem_data, held.data);
          end
          if (bus.mem_ack) begin
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_write addr=0x%0h data=0x%0h expected no write",
                       bus.mem_addr, bus.mem_data);
            end else begin
              exp = sb.pop_front();
              chk("drain_addr", bus.mem_addr, exp.addr);
              chk("drain_data", bus.mem_data, exp.data);
            end
            stalled = 1'b0;
          end else begin
            stalled   = 1'b1;
            held.addr = bus.mem_addr;
            held.data = bus.mem_data;
          end
        end else begin
          stalled = 1'b0;
        end
      end
    join_none

    // Reset and idle
    tick();
    tick();
    reset = 1'b0;
    chk("rst_wb_free", bus.wb_free, 2);
    chk("rst_wb_empty", bus.wb_empty, 1);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_overflow", bus.overflow_err, 0);
    tick();
    chk("idle_mem_req", bus.mem_req, 0);

    // Two-lane enqueue, back-to-back drain with ack held high
    bus.mem_ack = 1'b1;
    lane(0, 32'h104, 32'hB);
    lane(1, 32'h100, 32'hA);
    push(32'h104, 32'hB);
    push(32'h100, 32'hA);
    tick();
    bus.st_valid = '0;
    chk("a_req_latency", bus.mem_req, 0);
    chk("a_not_empty", bus.wb_empty, 0);
    tick();
    chk("a_req_high", bus.mem_req, 1);
    chk("a_head_addr", bus.mem_addr, 32'h104);
    tick();
    chk("a_second_addr", bus.mem_addr, 32'h100);
    tick();
    chk("a_empty_after", bus.wb_empty, 1);
    chk("a_req_low", bus.mem_req, 0);

    // Forwarding, youngest match wins, ack held low
    bus.mem_ack = 1'b0;
    lane(0, 32'h200, 32'h1);
    push(32'h200, 32'h1);
    tick();
    bus.st_valid = '0;
    tick();
    lane(0, 32'h200, 32'h2);
    push(32'h200, 32'h2);
    tick();
    bus.st_valid = '0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h200;
    #1;
    chk("fwd_hit", bus.ld_hit, 1);
    chk("fwd_youngest", bus.ld_data, 32'h2);
    bus.ld_addr = 32'h204;
    #1;
    chk("fwd_miss_hit", bus.ld_hit, 0);
    chk("fwd_miss_data", bus.ld_data, 0);
    lane(0, 32'h300, 32'h7);
    push(32'h300, 32'h7);
    bus.ld_addr = 32'h300;
    #1;
    chk("fwd_same_cycle_invisible", bus.ld_hit, 0);
    tick();
    bus.st_valid = '0;
    chk("fwd_next_cycle_hit", bus.ld_hit, 1);
    chk("fwd_next_cycle_data", bus.ld_data, 32'h7);
    bus.ld_valid = 1'b0;
    #1;
    chk("fwd_ld_valid_low", bus.ld_hit, 0);
    chk("fwd_ld_valid_low_data", bus.ld_data, 0);
    bus.mem_ack = 1'b1;
    drain("b", 20);
    bus.mem_ack = 1'b0;

    // Fill, sparse lane, pop+enqueue capacity, overflow
    for (int k = 0; k < 3; k++) begin
      lane(0, 32'h400 + 32'(8*k), 32'h40 + 32'(2*k));
      lane(1, 32'h404 + 32'(8*k), 32'h41 + 32'(2*k));
      push(32'h400 + 32'(8*k), 32'h40 + 32'(2*k));
      push(32'h404 + 32'(8*k), 32'h41 + 32'(2*k));
      tick();
    end
    bus.st_valid = '0;
    chk("c_free_at6", bus.wb_free, 2);
    lane(1, 32'h600, 32'h66);
    push(32'h600, 32'h66);
    tick();
    bus.st_valid = '0;
    chk("c_sparse_free", bus.wb_free, 1);
    lane(0, 32'h610, 32'h61);
    push(32'h610, 32'h61);
    tick();
    bus.st_valid = '0;
    chk("c_full_free", bus.wb_free, 0);
    chk("c_full_no_ovf", bus.overflow_err, 0);
    bus.mem_ack = 1'b1;
    tick();
    chk("c_after_pop_free", bus.wb_free, 1);
    lane(0, 32'h700, 32'h70);
    lane(1, 32'h704, 32'h71);
    push(32'h700, 32'h70);
    tick();
    bus.st_valid = '0;
    bus.mem_ack  = 1'b0;
    chk("d_pop_enq_free", bus.wb_free, 1);
    chk("d_pop_enq_ovf", bus.overflow_err, 1);
    lane(0, 32'h710, 32'h72);
    push(32'h710, 32'h72);
    tick();
    bus.st_valid = '0;
    chk("d_refill_free", bus.wb_free, 0);
    lane(1, 32'h720, 32'h73);
    tick();
    bus.st_valid = '0;
    chk("d_drop_free", bus.wb_free, 0);
    chk("d_drop_ovf", bus.overflow_err, 1);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h704;
    #1;
    chk("d_dropped_lane_not_fwd", bus.ld_hit, 0);
    bus.ld_addr = 32'h720;
    #1;
    chk("d_dropped_store_not_fwd", bus.ld_hit, 0);
    bus.ld_valid = 1'b0;
    bus.mem_ack  = 1'b1;
    drain("d", 30);
    chk("d_ovf_sticky", bus.overflow_err, 1);
    bus.mem_ack = 1'b0;

    // Reset while a request is outstanding
    lane(0, 32'h800, 32'h80);
    tick();
    bus.st_valid = '0;
    tick();
    chk("e_req_before_reset", bus.mem_req, 1);
    reset = 1'b1;
    #1;
    chk("e_req_drops", bus.mem_req, 0);
    chk("e_empty", bus.wb_empty, 1);
    chk("e_free", bus.wb_free, 2);
    chk("e_ovf_cleared", bus.overflow_err, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("e_req_stays_low", bus.mem_req, 0);

    // Twenty single stores with random ack stalls across pointer wrap
    issued = 0;
    n      = 0;
    while ((issued < 20 || !bus.wb_empty) && n < 600) begin
      bus.mem_ack  = 1'($urandom_range(0, 1));
      bus.st_valid = '0;
      if (issued < 20 && bus.wb_free != 0 && $urandom_range(0, 2) != 0) begin
        lane(0, 32'h1000 + 32'(4*issued), 32'hD000 + 32'(issued));
        push(32'h1000 + 32'(4*issued), 32'hD000 + 32'(issued));
        issued++;
      end
      tick();
      n++;
    end
    bus.st_valid = '0;
    bus.mem_ack  = 1'b0;
    chk("f_issued", issued, 20);
    chk("f_empty", bus.wb_empty, 1);
    chk("f_sb_left", sb.size(), 0);
    chk("f_no_ovf", bus.overflow_err, 0);
    tick();
    chk("f_req_low", bus.mem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
